// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch stage with in-order fetch queue
//
// Sits between the program counter and decode. It issues the current PC to
// instruction memory, keeps an in-order queue of fetched words tagged with
// their PC, and holds the PC (pc_stall) whenever no fetch is accepted.
// A flush empties the queue and arranges for every response still in flight
// to be dropped when it returns.
//
// Parameters:
//   DEPTH           - queue entries (power of two, >= 2)
//   MAX_OUTSTANDING - memory requests allowed in flight (1..DEPTH)
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   instr_addr          - current PC from the program counter
//   pc_stall            - high holds the PC (drives no_update)
//   mem_req_valid/ready - fetch request handshake, address on mem_req_addr
//   mem_resp_valid/data - in-order fetch responses, always accepted
//   flush               - redirect; drops queued and in-flight fetches
//   out_valid/ready     - head entry handshake towards decode
//   out_instr/pc/fault  - head entry contents
//
// Build option:
//   IFQ_ALIGN_CHECK_EN - when defined, a misaligned PC is not sent to memory;
//                        a pre-filled fault entry carrying a NOP is queued
//                        instead. When undefined, out_fault is always 0.

module instr_fetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic        pc_stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [OW:0]   MAX_OUT_C = (OW + 1)'(MAX_OUTSTANDING);
  localparam logic [31:0]   NOP_INSTR = 32'h00000013;

  // Queue storage
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] filled_d;
  logic [DEPTH-1:0] fault_q;
  logic [DEPTH-1:0] fault_d;

  // Pointers and counters
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  // Per-cycle events
  logic          misaligned;
  logic          req_room;
  logic          budget_ok;
  logic          fire;
  logic          fault_alloc;
  logic          alloc;
  logic          pop;
  logic          drop;
  logic          fill;
  logic          fill_found;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] scan_idx;

`ifdef IFQ_ALIGN_CHECK_EN
  assign misaligned = (instr_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req_addr = instr_addr;

  // Request, stall and output handshake
  always_comb begin
    req_room      = (count_q < DEPTH_C);
    // Responses still owed to dropped fetches occupy the memory budget too.
    budget_ok     = (({1'b0, outstanding_q} + {1'b0, discard_q}) < MAX_OUT_C);
    mem_req_valid = !reset && !flush && req_room && budget_ok && !misaligned;
    fire          = mem_req_valid && mem_req_ready;
    // A misaligned PC takes a queue slot without touching memory.
    fault_alloc   = !reset && !flush && req_room && misaligned;
    alloc         = fire || fault_alloc;
    pc_stall      = reset || !(fire || flush || fault_alloc);

    out_valid     = filled_q[head_q];
    out_pc        = out_valid ? pc_mem_q[head_q]    : 32'h0;
    out_instr     = out_valid ? instr_mem_q[head_q] : 32'h0;
    out_fault     = out_valid && fault_q[head_q];
    pop           = out_valid && out_ready && !flush;
  end

  // A response belongs to the oldest allocated entry that is still unfilled.
  // Fault entries are born filled, so a plain head-to-tail scan skips them.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!fill_found && (CW'(i) < count_q) && !filled_q[scan_idx]) begin
        fill_found = 1'b1;
        fill_idx   = scan_idx;
      end
    end
    drop = mem_resp_valid && (discard_q != '0);
    fill = mem_resp_valid && (discard_q == '0) && fill_found;
  end

  // Next-state for queue and counters
  always_comb begin
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;
    filled_d      = filled_q;
    fault_d       = fault_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (flush) begin
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      outstanding_d = '0;
      filled_d      = '0;
      fault_d       = '0;
      // Every request still unanswered becomes a response to throw away; a
      // response arriving right now retires one of them immediately.
      discard_d     = discard_q + outstanding_q
                    - OW'(mem_resp_valid && ((discard_q != '0) || (outstanding_q != '0)));
    end else begin
      // Pop, fill and allocate never collide on one slot: pop takes a filled
      // head, fill an unfilled allocated slot, allocate a free tail slot.
      if (pop) begin
        filled_d[head_q] = 1'b0;
        fault_d[head_q]  = 1'b0;
        head_d           = head_q + PW'(1);
      end
      if (fill) begin
        instr_mem_d[fill_idx] = mem_resp_data;
        filled_d[fill_idx]    = 1'b1;
      end
      if (alloc) begin
        pc_mem_d[tail_q]    = instr_addr;
        instr_mem_d[tail_q] = fault_alloc ? NOP_INSTR : 32'h0;
        filled_d[tail_q]    = fault_alloc;
        fault_d[tail_q]     = fault_alloc;
        tail_d              = tail_q + PW'(1);
      end
      count_d       = count_q + CW'(alloc) - CW'(pop);
      outstanding_d = outstanding_q + OW'(fire) - OW'(fill);
      discard_d     = discard_q - OW'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0;
        instr_mem_q[i] <= 32'h0;
      end
      filled_q      <= '0;
      fault_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
      filled_q      <= filled_d;
      fault_q       <= fault_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule
